fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch and phase sequencer directly upstream of the decode stage.
- Consumes program_byte from the ROM and c_flag/z_flag from the flags register.
- Produces the registered instr/oprnd pair, the phase bit and a 12-bit jump target for decode.
- Issues the PC increment/load strobes, and handles two-byte jump instructions and a halt opcode.

Parameters:
- PC_W, 12, width of jump target / program counter address.
- HALT_BYTE, 8'hFF, program byte that halts the sequencer.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = sequencer advances; 0 = all state holds (stall).
- program_byte  in  8  ROM data at current PC.
- c_flag  in  1  registered carry flag.
- z_flag  in  1  registered zero flag.
- phase  out  1  0 = fetch (S_FETCH, S_FETCH_EXT), 1 = execute (S_EXEC).
- instr  out  4  latched opcode (program_byte[7:4]).
- oprnd  out  4  latched operand (program_byte[3:0]).
- jump_addr  out  PC_W  {oprnd, second byte}, valid in S_EXEC of a jump.
- inc_pc  out  1  PC increment request.
- load_pc  out  1  PC load request (jump taken); PC loads jump_addr.
- exec_valid  out  1  one-cycle execute strobe for decode.
- halted  out  1  sequencer is in S_HALT.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All state updates on the rising edge of clock.
- Reset values: state = S_FETCH, instr = 0, oprnd = 0, jump_addr = 0, phase = 0, inc_pc = 0, load_pc = 0, exec_valid = 0, halted = 0.
  - Reset wins over enable and over every state, including mid-fetch of a two-byte jump.
- Opcodes:
  - Two-byte jumps: JC = 4'b0100, JNC = 4'b0101, JZ = 4'b0110, JNZ = 4'b0111, JMP = 4'b1000.
  - All other opcodes are single-byte.
- FSM states: S_FETCH, S_FETCH_EXT, S_EXEC, S_HALT.
- Strobe outputs (inc_pc, load_pc, exec_valid, halted, phase):
  - Moore, decoded combinationally from the registered state, instr and flags.
  - Gated low when enable = 0, except halted and phase.
- S_FETCH (phase = 0, inc_pc = 1):
  - On the edge, latch instr/oprnd from program_byte.
  - program_byte == HALT_BYTE -> S_HALT.
  - Jump opcode -> S_FETCH_EXT.
  - Otherwise -> S_EXEC.
- S_FETCH_EXT (phase = 0, inc_pc = 1):
  - On the edge, latch jump_addr = {oprnd, program_byte}, then -> S_EXEC.
- S_EXEC (phase = 1, exec_valid = 1, inc_pc = 0) -> S_FETCH.
  - load_pc = 1 only when the jump condition holds: JMP always; JC on c_flag = 1; JNC on c_flag = 0; JZ on z_flag = 1; JNZ on z_flag = 0.
  - Flags are sampled in this cycle.
  - Non-jump opcodes never assert load_pc.
- S_HALT: halted = 1, all strobes 0, phase = 0. Left only by reset.
- enable = 0: state and all registers hold; strobes forced 0, so no double increment on stall.
- Single-byte instruction latency: 2 cycles (FETCH, EXEC). Jump latency: 3 cycles.
- PC wrap-around is owned by the program counter; this block never inspects the PC.

Optional Feature:
- Macro: FETCH_SEQ_SINGLE_STEP_EN.
- When defined:
  - Add input step (1 bit).
  - S_EXEC leaves to S_FETCH only on a cycle with step = 1; exec_valid and load_pc are asserted only in that cycle.
  - step in any other state is ignored.
- When undefined: no step port; S_EXEC always lasts exactly one enabled cycle.

Decomposition:
- Shared package fetch_seq_pkg:
  - State enum (S_FETCH, S_FETCH_EXT, S_EXEC, S_HALT).
  - Opcode constants OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP.
  - Function is_jump(instr).
- One natural sub-module, jump_cond: combinational, takes instr, c_flag and z_flag, returns taken.

Test Plan:
- Reset, then ROM byte 8'h23 -> cycle 1 inc_pc = 1, phase = 0; cycle 2 instr = 2, oprnd = 3, exec_valid = 1, phase = 1, load_pc = 0.
- JMP bytes 8'h81, 8'h2C -> two inc_pc cycles; S_EXEC shows jump_addr = 12'h12C, load_pc = 1, inc_pc = 0.
- JZ 8'h6A, 8'h00 with z_flag = 0 -> load_pc = 0 in EXEC; repeat with z_flag = 1 -> load_pc = 1, jump_addr = 12'hA00.
- enable low for 3 cycles during S_FETCH_EXT -> no strobes, state held; after enable = 1, exactly one further inc_pc before exec_valid.
- Byte 8'hFF -> halted = 1 next cycle and stays; strobes 0 for 10+ cycles; reset returns to S_FETCH with all outputs zero.
- Reset asserted during S_FETCH_EXT of a JC -> next cycle state S_FETCH, jump_addr = 0, no load_pc.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding, jump opcodes
// and the jump-opcode classifier used by the fetch decision.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_FETCH_EXT = 2'd1,
        S_EXEC      = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [3:0] OP_JC  = 4'b0100;
    localparam logic [3:0] OP_JNC = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_JNZ = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;

    // Jumps are the only two-byte instructions; they need the extra fetch.
    function automatic logic is_jump(input logic [3:0] op);
        return (op inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP});
    endfunction

endpackage

// File: rtl/fetch_sequencer_jump_cond.sv
// Jump condition evaluation: decides whether the latched jump opcode is
// taken given the current carry/zero flags. Non-jumps are never taken.
module jump_cond
    import fetch_seq_pkg::*;
(
    input  logic [3:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
    output logic       taken
);

    // Opcode-to-condition decode
    always_comb begin
        taken = 1'b0;
        case (instr)
            OP_JMP:  taken = 1'b1;
            OP_JC:   taken = c_flag;
            OP_JNC:  taken = ~c_flag;
            OP_JZ:   taken = z_flag;
            OP_JNZ:  taken = ~z_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / phase sequencer feeding decode. Latches opcode and
// operand, collects the second byte of jumps into jump_addr, and issues
// PC increment/load strobes. Strobes are decoded from registered state and
// are suppressed while stalled (enable = 0) or held in reset, so a stall
// never produces a double increment.
// Optional build macro FETCH_SEQ_SINGLE_STEP_EN adds a 'step' input that
// holds S_EXEC until step = 1.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int         PC_W      = 12,
    parameter logic [7:0] HALT_BYTE = 8'hFF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      program_byte,
    input  logic            c_flag,
    input  logic            z_flag,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            phase,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic [PC_W-1:0] jump_addr,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            exec_valid,
    output logic            halted
);

    state_t state;
    logic   taken;
    logic   step_ok;
    logic   run;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    jump_cond u_jump_cond (
        .instr  (instr),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .taken  (taken)
    );

    // Fetch/execute FSM with the instruction and jump-target registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            instr     <= 4'd0;
            oprnd     <= 4'd0;
            jump_addr <= '0;
        end else if (enable) begin
            case (state)
                S_FETCH: begin
                    instr <= program_byte[7:4];
                    oprnd <= program_byte[3:0];
                    // Halt takes priority so a HALT_BYTE override never
                    // gets mistaken for a jump.
                    if (program_byte == HALT_BYTE)
                        state <= S_HALT;
                    else if (is_jump(program_byte[7:4]))
                        state <= S_FETCH_EXT;
                    else
                        state <= S_EXEC;
                end
                S_FETCH_EXT: begin
                    jump_addr <= PC_W'({oprnd, program_byte});
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    if (step_ok)
                        state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Strobe decode; reset also masks them so nothing leaks out while held
    assign run        = enable & ~reset;
    assign inc_pc     = run & ((state == S_FETCH) | (state == S_FETCH_EXT));
    assign exec_valid = run & (state == S_EXEC) & step_ok;
    assign load_pc    = exec_valid & taken;
    assign phase      = (state == S_EXEC);
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed cases followed by a
// random instruction stream with random stalls. Expected behaviour is
// generated per instruction as a cycle trace (fetch, optional extension
// byte, execute) from the opcode rules, not from the DUT's state.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  program_byte = 8'h00;
    logic        c_flag = 1'b0;
    logic        z_flag = 1'b0;
    logic        step = 1'b1;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [11:0] jump_addr;
    logic        inc_pc;
    logic        load_pc;
    logic        exec_valid;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .program_byte (program_byte),
        .c_flag       (c_flag),
        .z_flag       (z_flag),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .phase        (phase),
        .instr        (instr),
        .oprnd        (oprnd),
        .jump_addr    (jump_addr),
        .inc_pc       (inc_pc),
        .load_pc      (load_pc),
        .exec_valid   (exec_valid),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs on the falling edge, then let outputs settle
    task automatic drive(input logic [7:0] pb, input logic en, input logic c, input logic z);
        @(negedge clock);
        reset        = 1'b0;
        program_byte = pb;
        enable       = en;
        c_flag       = c;
        z_flag       = z;
        #1;
    endtask

    function automatic logic is_jmp_op(input logic [3:0] op);
        return (op >= 4'd4) && (op <= 4'd8);
    endfunction

    function automatic logic cond_holds(input logic [3:0] op, input logic c, input logic z);
        return (op == 4'd8) || (op == 4'd4 && c) || (op == 4'd5 && !c) ||
               (op == 4'd6 && z) || (op == 4'd7 && !z);
    endfunction

    task automatic strobes_idle(input string tag, input logic exp_phase);
        chk({tag, ".inc"}, inc_pc, 0);
        chk({tag, ".exec"}, exec_valid, 0);
        chk({tag, ".load"}, load_pc, 0);
        chk({tag, ".phase"}, phase, exp_phase);
    endtask

    // Stalled cycles: nothing is strobed and the phase stays put
    task automatic stall(input int n, input logic exp_phase);
        for (int i = 0; i < n; i++) begin
            drive(8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            strobes_idle("stall", exp_phase);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        enable       = 1'($urandom);
        program_byte = 8'($urandom);
        @(negedge clock);
        #1;
        strobes_idle("rst", 1'b0);
        chk("rst.halted", halted, 0);
        chk("rst.instr", instr, 0);
        chk("rst.oprnd", oprnd, 0);
        chk("rst.jaddr", jump_addr, 0);
    endtask

    // One whole instruction: fetch, optional second byte, execute
    task automatic run_instr(input logic [7:0] b1, input logic [7:0] b2,
                             input logic c, input logic z, input int max_stall);
        logic jmp;
        jmp = is_jmp_op(b1[7:4]);
        stall($urandom_range(max_stall, 0), 1'b0);
        drive(b1, 1'b1, 1'($urandom), 1'($urandom));
        chk("fetch.inc", inc_pc, 1);
        chk("fetch.phase", phase, 0);
        chk("fetch.exec", exec_valid, 0);
        if (jmp) begin
            stall($urandom_range(max_stall, 0), 1'b0);
            drive(b2, 1'b1, 1'($urandom), 1'($urandom));
            chk("ext.inc", inc_pc, 1);
            chk("ext.phase", phase, 0);
            chk("ext.exec", exec_valid, 0);
        end
        stall($urandom_range(max_stall, 0), 1'b1);
        drive(8'($urandom), 1'b1, c, z);
        chk("exec.phase", phase, 1);
        chk("exec.valid", exec_valid, 1);
        chk("exec.inc", inc_pc, 0);
        chk("exec.instr", instr, b1[7:4]);
        chk("exec.oprnd", oprnd, b1[3:0]);
        chk("exec.load", load_pc, jmp ? cond_holds(b1[7:4], c, z) : 1'b0);
        if (jmp) chk("exec.jaddr", jump_addr, {b1[3:0], b2});
    endtask

    initial begin
        logic [7:0] b1;

        do_reset();

        // Single-byte instruction and unconditional jump
        run_instr(8'h23, 8'h00, 1'b0, 1'b0, 0);
        run_instr(8'h81, 8'h2C, 1'b0, 1'b0, 0);
        chk("jmp.addr", jump_addr, 12'h12C);

        // JZ not taken then taken
        run_instr(8'h6A, 8'h00, 1'b1, 1'b0, 0);
        run_instr(8'h6A, 8'h00, 1'b0, 1'b1, 0);
        chk("jz.addr", jump_addr, 12'hA00);

        // Three stalled cycles inside the extension fetch
        drive(8'h53, 1'b1, 1'b0, 1'b0);
        chk("sx.fetch.inc", inc_pc, 1);
        stall(3, 1'b0);
        drive(8'h9E, 1'b1, 1'b0, 1'b0);
        chk("sx.ext.inc", inc_pc, 1);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        chk("sx.exec", exec_valid, 1);
        chk("sx.inc", inc_pc, 0);
        chk("sx.load", load_pc, 1);
        chk("sx.jaddr", jump_addr, 12'h39E);

        // Halt: sticky until reset, no strobes regardless of enable
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("halt.fetch.inc", inc_pc, 1);
        for (int i = 0; i < 12; i++) begin
            drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("halt.halted", halted, 1);
            strobes_idle("halt", 1'b0);
        end
        do_reset();
        run_instr(8'h17, 8'h00, 1'b0, 1'b0, 0);

        // Reset during the second byte of a JC
        drive(8'h45, 1'b1, 1'b1, 1'b0);
        chk("rj.fetch.inc", inc_pc, 1);
        @(negedge clock);
        reset = 1'b1; enable = 1'b1; program_byte = 8'h77; c_flag = 1'b1;
        #1;
        chk("rj.load", load_pc, 0);
        drive(8'h23, 1'b1, 1'b1, 1'b0);
        chk("rj.inc", inc_pc, 1);
        chk("rj.phase", phase, 0);
        chk("rj.jaddr", jump_addr, 0);
        chk("rj.instr", instr, 0);
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        chk("rj.exec", exec_valid, 1);
        chk("rj.exload", load_pc, 0);
        chk("rj.exinstr", instr, 2);

        // Random instruction stream with random stalls
        for (int k = 0; k < 300; k++) begin
            b1 = 8'($urandom);
            if ($urandom_range(2, 0) == 0) b1[7:4] = 4'($urandom_range(8, 4));
            if (b1 == 8'hFF) b1 = 8'hFE;
            run_instr(b1, 8'($urandom), 1'($urandom), 1'($urandom), 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
